dist_ram_fifo_ctrl: RTL and testbench

Sequencing controller that turns one `dist_ram` instance into a first-in/first-out buffer with valid/ready handshakes on both sides. It owns the write and read pointers, drives the RAM's write port (`in_addr`, `data_in`, `write_en`) and read address (`out_addr`), and registers RAM read data into an output stage. It sits between a producer, such as a host loader or result writeback, and a TPU consumer, such as the weight or activation feed.

---
 rtl/tpu_pkg.sv | 18 +
 rtl/dist_ram.sv | 33 +++
 rtl/dist_ram_fifo_ctrl.sv | 110 +++++++++++
 tb/tb_dist_ram_fifo_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tpu_pkg                                                                    |
// | Shared sizing constants and helpers for the on-chip TPU buffers.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package tpu_pkg;

    localparam int TPU_DATA_WIDTH = 8;
    localparam int TPU_DATA_DEPTH = 32;

    // Pointer width for a buffer of the given depth; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dist_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dist_ram                                                                   |
// | Distributed RAM: synchronous write port, combinational read port.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dist_ram
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH    = TPU_DATA_WIDTH,
    parameter int DATA_DEPTH    = TPU_DATA_DEPTH,
    parameter int ADDRESS_WIDTH = ptr_width(TPU_DATA_DEPTH)
) (
    input  logic                     clk,
    input  logic                     write_en,
    input  logic [ADDRESS_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [ADDRESS_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]    data_out
);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[in_addr] <= data_in;
        end
    end

    assign data_out = mem_q[out_addr];

endmodule
`default_nettype wire

// File: rtl/dist_ram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dist_ram_fifo_ctrl                                                         |
// | Valid/ready FIFO built from one dist_ram plus a registered output stage.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dist_ram_fifo_ctrl
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH    = TPU_DATA_WIDTH,
    parameter int DATA_DEPTH    = TPU_DATA_DEPTH,
    parameter int ADDRESS_WIDTH = ptr_width(TPU_DATA_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE   = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = (ADDRESS_WIDTH + 1)'(1);
    localparam logic [ADDRESS_WIDTH:0]   CNT_DEPTH = (ADDRESS_WIDTH + 1)'(DATA_DEPTH);

    if (DATA_DEPTH != (1 << ADDRESS_WIDTH)) begin : g_depth_check
        $fatal(1, "dist_ram_fifo_ctrl: DATA_DEPTH must equal 2**ADDRESS_WIDTH");
    end

    logic [ADDRESS_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDRESS_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDRESS_WIDTH:0]   ram_cnt_q,   ram_cnt_d;
    logic                     out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]    out_data_q,  out_data_d;

    logic                     w_accept;
    logic                     w_load;
    logic [DATA_WIDTH-1:0]    w_ram_rdata;

    // in_ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign full     = (ram_cnt_q == CNT_DEPTH);
    assign in_ready = !full && !rst && !flush;
    assign w_accept = in_valid && in_ready;
    assign w_load   = (ram_cnt_q != '0) && (!out_valid_q || out_ready);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (w_load) begin
            out_data_d  = w_ram_rdata;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
        end else if (out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
        case ({w_accept, w_load})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    dist_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .DATA_DEPTH    (DATA_DEPTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clk      (clk),
        .write_en (w_accept),
        .in_addr  (wr_ptr_q),
        .data_in  (in_data),
        .out_addr (rd_ptr_q),
        .data_out (w_ram_rdata)
    );

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign count     = ram_cnt_q + {{ADDRESS_WIDTH{1'b0}}, out_valid_q};
    assign empty     = (count == '0);

endmodule
`default_nettype wire

// File: tb/tb_dist_ram_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dist_ram_fifo_ctrl                                                      |
// | Scenario tasks plus randomized traffic against a queue-based FIFO model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dist_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, full, empty;
    logic [7:0] out_data;
    logic [5:0] count;

    int checks = 0;
    int errors = 0;

    logic       obs_in_ready;
    logic [7:0] got[$];
    logic [7:0] m_ram[$];
    logic       m_ov;
    logic [7:0] m_od;

    always #5 clk = ~clk;

    dist_ram_fifo_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    function automatic int m_count();
        return m_ram.size() + (m_ov ? 1 : 0);
    endfunction

    // Applies inputs for one clock, records consumed words, advances the model.
    task automatic tick(input logic iv, input logic [7:0] d, input logic ordy,
                        input logic r = 1'b0, input logic f = 1'b0);
        logic acc, ld;
        in_valid = iv; in_data = d; out_ready = ordy; rst = r; flush = f;
        #1;
        obs_in_ready = in_ready;
        if (!r && !f && out_valid === 1'b1 && ordy) got.push_back(out_data);
        @(posedge clk);
        if (r || f) begin
            m_ram.delete(); m_ov = 1'b0; m_od = 8'h00;
        end else begin
            acc = iv && (m_ram.size() < 32);
            ld  = (m_ram.size() > 0) && (!m_ov || ordy);
            if (ld) begin
                m_od = m_ram.pop_front(); m_ov = 1'b1;
            end else if (ordy && m_ov) begin
                m_ov = 1'b0;
            end
            if (acc) m_ram.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 8'h55, 1'b1, 1'b1);
        checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", obs_in_ready); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp=1/0", empty, full); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL reset_out valid=%b data=%h exp=0/00", out_valid, out_data); end
        tick(1'b0, 8'h00, 1'b0);
        checks++; if (obs_in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b exp=1", obs_in_ready); end
    endtask

    task automatic test_single();
        got.delete();
        tick(1'b1, 8'hAB, 1'b0);
        checks++; if (out_valid !== 1'b0 || count !== 6'd1) begin errors++; $display("FAIL single_edge_k valid=%b count=%0d exp=0/1", out_valid, count); end
        tick(1'b0, 8'h00, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hAB) begin errors++; $display("FAIL single_edge_k1 valid=%b data=%h exp=1/ab", out_valid, out_data); end
        tick(1'b0, 8'h00, 1'b1);
        checks++; if (empty !== 1'b1 || got.size() != 1) begin errors++; $display("FAIL single_consume empty=%b consumed=%0d exp=1/1", empty, got.size()); end
    endtask

    task automatic fill33(input logic [7:0] base);
        for (int i = 0; i < 33; i++) tick(1'b1, base + 8'(i), 1'b0);
    endtask

    task automatic test_fill();
        int bad = 0;
        got.delete();
        fill33(8'h00);
        checks++; if (count !== 6'd33 || full !== 1'b1) begin errors++; $display("FAIL fill_level count=%0d full=%b exp=33/1", count, full); end
        tick(1'b1, 8'h99, 1'b0);
        checks++; if (obs_in_ready !== 1'b0 || count !== 6'd33) begin errors++; $display("FAIL fill_34th in_ready=%b count=%0d exp=0/33", obs_in_ready, count); end
        for (int i = 0; i < 36; i++) tick(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i)) bad++;
        checks++; if (got.size() != 33 || bad != 0) begin errors++; $display("FAIL fill_drain words=%0d misordered=%0d exp=33/0", got.size(), bad); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty got=%b exp=1", empty); end
    endtask

    task automatic test_stream();
        int bad_rate = 0, bad_cnt = 0, bad_ord = 0;
        got.delete();
        for (int i = 0; i < 102; i++) begin
            tick(i < 100, 8'(i), 1'b1);
            if (got.size() != ((i >= 1) ? i - 1 : 0)) bad_rate++;
            if (count > 6'd2) bad_cnt++;
        end
        for (int i = 0; i < got.size(); i++) if (got[i] !== 8'(i)) bad_ord++;
        checks++; if (bad_rate != 0) begin errors++; $display("FAIL stream_rate bad_cycles=%0d exp=0", bad_rate); end
        checks++; if (bad_cnt != 0) begin errors++; $display("FAIL stream_count over2_cycles=%0d exp=0", bad_cnt); end
        checks++; if (got.size() != 100 || bad_ord != 0) begin errors++; $display("FAIL stream_order words=%0d misordered=%0d exp=100/0", got.size(), bad_ord); end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] exp_q[$];
        int bad = 0;
        got.delete();
        fill33(8'h40);
        tick(1'b1, 8'h77, 1'b1);
        checks++; if (obs_in_ready !== 1'b0 || count !== 6'd32) begin errors++; $display("FAIL pushpop_refused in_ready=%b count=%0d exp=0/32", obs_in_ready, count); end
        tick(1'b1, 8'h77, 1'b0);
        checks++; if (obs_in_ready !== 1'b1 || count !== 6'd33) begin errors++; $display("FAIL pushpop_refill in_ready=%b count=%0d exp=1/33", obs_in_ready, count); end
        for (int i = 0; i < 36; i++) tick(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 33; i++) exp_q.push_back(8'h40 + 8'(i));
        exp_q.push_back(8'h77);
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) bad++;
        checks++; if (got.size() != exp_q.size() || bad != 0) begin errors++; $display("FAIL pushpop_order words=%0d misordered=%0d exp=34/0", got.size(), bad); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        got.delete();
        tick(1'b1, 8'h33, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(i == 0, 8'hFE, 1'b0);
            if (out_valid !== 1'b1 || out_data !== 8'h33) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable bad_cycles=%0d exp=0 data=%h", bad, out_data); end
        tick(1'b0, 8'h00, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hFE) begin errors++; $display("FAIL hold_next valid=%b data=%h exp=1/fe", out_valid, out_data); end
        tick(1'b0, 8'h00, 1'b1);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hold_drain empty=%b exp=1", empty); end
    endtask

    task automatic test_flush_reset();
        for (int k = 0; k < 2; k++) begin
            got.delete();
            for (int i = 0; i < 10; i++) tick(1'b1, 8'hA0 + 8'(i), 1'b0);
            checks++; if (count !== 6'd10) begin errors++; $display("FAIL clr%0d_pre count=%0d exp=10", k, count); end
            tick(1'b1, 8'hDE, 1'b0, k == 1, k == 0);
            checks++; if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL clr%0d_in_ready got=%b exp=0", k, obs_in_ready); end
            checks++; if (count !== 6'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL clr%0d_state count=%0d valid=%b empty=%b exp=0/0/1", k, count, out_valid, empty); end
            tick(1'b1, 8'h5A, 1'b0);
            checks++; if (dut.u_ram.mem_q[0] !== 8'h5A) begin errors++; $display("FAIL clr%0d_addr0 mem0=%h exp=5a", k, dut.u_ram.mem_q[0]); end
            for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b1);
            checks++; if (got.size() != 1 || got[0] !== 8'h5A) begin errors++; $display("FAIL clr%0d_output words=%0d first=%h exp=1/5a", k, got.size(), (got.size() > 0) ? got[0] : 8'h00); end
        end
    endtask

    task automatic test_random();
        int bad = 0;
        logic iv, ordy, f, exp_ir;
        logic [7:0] d;
        for (int i = 0; i < 600; i++) begin
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 75));
            f    = ($urandom_range(0, 199) == 0);
            d    = 8'($urandom);
            exp_ir = (m_ram.size() < 32) && !f;
            tick(iv, d, ordy, 1'b0, f);
            if (obs_in_ready !== exp_ir || count !== 6'(m_count()) || out_valid !== m_ov ||
                (m_ov && out_data !== m_od) || full !== (m_ram.size() == 32) ||
                empty !== (m_count() == 0)) begin
                bad++;
                if (bad <= 5) $display("FAIL random_cycle%0d count=%0d/%0d valid=%b/%b data=%h/%h in_ready=%b/%b",
                                       i, count, m_count(), out_valid, m_ov, out_data, m_od, obs_in_ready, exp_ir);
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL random_total bad_cycles=%0d exp=0", bad); end
    endtask

    initial begin
        m_ov = 1'b0; m_od = 8'h00;
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_full_pushpop();
        test_backpressure();
        test_flush_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
